core_sequencer: RTL

Parametrised multi-cycle core control sequencer, the successor to the current fixed microprogram control. It drives fetch, execute and memory phases from a decoded instruction class. It adds three behaviours: a memory-timeout bus fault, N-instruction debug stepping, and burst abstract memory access. It sits between the decoder/datapath and the debug module.

---
 rtl/core_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle core control sequencer: fetch/exec/mem phases with bus-fault timeout,
// N-instruction debug stepping and burst abstract register/memory access.
module core_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned STEP_W  = 8,
    parameter int unsigned BURST_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [2:0]         i_instr_class,
    input  logic               i_mem_complete,
    input  logic               i_exception,
    input  logic               i_interrupt_pending,
    input  logic               i_debug,
    input  logic               i_step_en,
    input  logic [STEP_W-1:0]  i_step_count,
    input  logic               i_abstract,
    input  logic [1:0]         i_abs_cmd,
    input  logic               i_abs_csr,
    input  logic [BURST_W-1:0] i_abs_count,
    output logic               o_write_ir,
    output logic               o_write_pc,
    output logic               o_pc_sel,
    output logic               o_write_rd,
    output logic [1:0]         o_rd_sel,
    output logic               o_write_csr,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [1:0]         o_addr_sel,
    output logic               o_abs_addr_inc,
    output logic               o_abstract_write,
    output logic               o_abstract_done,
    output logic               o_abs_error,
    output logic               o_bus_fault,
    output logic               o_halted,
    output logic               o_step_done
);
    localparam int unsigned TmoW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] ClsAlu    = 3'd0;
    localparam logic [2:0] ClsJump   = 3'd1;
    localparam logic [2:0] ClsBranch = 3'd2;
    localparam logic [2:0] ClsLoad   = 3'd3;
    localparam logic [2:0] ClsStore  = 3'd4;
    localparam logic [2:0] ClsCsr    = 3'd5;
    localparam logic [2:0] ClsWfi    = 3'd6;
    localparam logic [2:0] ClsFence  = 3'd7;

    typedef enum logic [3:0] {
        StResetChk, StFetch, StExec, StMem, StMemWb, StWait,
        StHalted, StAbsReg, StAbsMem, StAbsNext, StAbsDone
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [TmoW-1:0]    r_tmo_cnt;
    logic [STEP_W-1:0]  r_step_cnt;
    logic               r_step_act;
    logic [1:0]         r_abs_cmd;
    logic               r_abs_csr;
    logic [BURST_W-1:0] r_burst;
    logic               r_abs_err;
    logic               r_mem_store;

    logic w_core, w_req, w_fault, w_retire, w_trap, w_step_ev, w_tmo_clr;

    assign w_core  = r_state inside {StFetch, StExec, StMem, StMemWb, StWait};
    assign w_req   = r_state inside {StFetch, StMem, StAbsMem};
    assign w_fault = (TIMEOUT != 0) && w_req && !i_mem_complete &&
                     (r_tmo_cnt == TmoW'(TIMEOUT));
    assign w_tmo_clr = !w_req || i_mem_complete || w_fault || w_step_ev ||
                       (w_state_nxt != r_state);

    always_comb begin
        o_write_ir       = 1'b0;
        o_write_pc       = 1'b0;
        o_pc_sel         = 1'b0;
        o_write_rd       = 1'b0;
        o_rd_sel         = 2'd0;
        o_write_csr      = 1'b0;
        o_mem_read       = 1'b0;
        o_mem_write      = 1'b0;
        o_addr_sel       = 2'd0;
        o_abs_addr_inc   = 1'b0;
        o_abstract_write = 1'b0;
        o_abstract_done  = 1'b0;
        o_abs_error      = 1'b0;
        o_bus_fault      = 1'b0;
        o_halted         = 1'b0;
        o_step_done      = 1'b0;
        w_state_nxt      = r_state;
        w_retire         = 1'b0;
        w_trap           = 1'b0;
        w_step_ev        = 1'b0;
        // Outputs stay quiet while reset is held so no request leaks out mid-reset
        if (i_rst_n) begin
            unique case (r_state)
                StResetChk: w_state_nxt = i_debug ? StHalted : StFetch;
                StFetch: begin
                    if (!w_fault) begin
                        o_mem_read = 1'b1;
                        if (i_mem_complete) begin
                            o_write_ir  = 1'b1;
                            w_state_nxt = StExec;
                        end
                    end
                end
                StExec: begin
                    case (i_instr_class)
                        ClsAlu, ClsJump: begin
                            o_write_rd = 1'b1;
                            w_retire   = 1'b1;
                        end
                        ClsBranch, ClsFence: w_retire = 1'b1;
                        ClsCsr: begin
                            o_write_rd  = 1'b1;
                            o_rd_sel    = 2'd2;
                            o_write_csr = 1'b1;
                            w_retire    = 1'b1;
                        end
                        ClsLoad, ClsStore: w_state_nxt = StMem;
                        ClsWfi: begin
                            if (i_interrupt_pending || i_debug || r_step_act) w_retire = 1'b1;
                            else w_state_nxt = StWait;
                        end
                        default: w_retire = 1'b1;
                    endcase
                end
                StMem: begin
                    o_addr_sel = 2'd1;
                    if (!w_fault) begin
                        o_mem_read  = !r_mem_store;
                        o_mem_write = r_mem_store;
                        if (i_mem_complete) begin
                            if (r_mem_store) w_retire = 1'b1;
                            else w_state_nxt = StMemWb;
                        end
                    end
                end
                StMemWb: begin
                    o_write_rd = 1'b1;
                    o_rd_sel   = 2'd1;
                    w_retire   = 1'b1;
                end
                StWait: w_retire = i_interrupt_pending || i_debug;
                StHalted: begin
                    o_halted = 1'b1;
                    if (i_abstract) w_state_nxt = i_abs_cmd[1] ? StAbsMem : StAbsReg;
                    else if (!i_debug) w_state_nxt = StFetch;
                end
                StAbsReg: begin
                    if (!r_abs_cmd[0]) begin
                        o_abstract_write = 1'b1;
                        o_rd_sel         = r_abs_csr ? 2'd2 : 2'd0;
                    end else if (r_abs_csr) begin
                        o_write_csr = 1'b1;
                    end else begin
                        o_write_rd = 1'b1;
                        o_rd_sel   = 2'd3;
                    end
                    w_state_nxt = StAbsDone;
                end
                StAbsMem: begin
                    o_addr_sel = 2'd2;
                    if (w_fault) begin
                        w_state_nxt = StAbsDone;
                    end else begin
                        o_mem_read  = !r_abs_cmd[0];
                        o_mem_write = r_abs_cmd[0];
                        if (i_mem_complete) begin
                            o_abstract_write = !r_abs_cmd[0];
                            o_rd_sel         = r_abs_cmd[0] ? 2'd0 : 2'd1;
                            w_state_nxt      = (r_burst == '0) ? StAbsDone : StAbsNext;
                        end
                    end
                end
                StAbsNext: begin
                    o_abs_addr_inc = 1'b1;
                    w_state_nxt    = StAbsMem;
                end
                StAbsDone: begin
                    o_abstract_done = 1'b1;
                    o_abs_error     = r_abs_err;
                    w_state_nxt     = StHalted;
                end
                default: w_state_nxt = StResetChk;
            endcase

            // A trap overrides whatever the phase wanted to commit this cycle
            w_trap = w_core && (i_exception || w_fault);
            if (w_trap) begin
                o_write_rd  = 1'b0;
                o_write_csr = 1'b0;
                o_mem_write = 1'b0;
                o_write_pc  = 1'b1;
                o_pc_sel    = 1'b1;
            end else if (w_retire) begin
                o_write_pc = 1'b1;
            end
            w_step_ev = w_trap || w_retire;
            if (w_step_ev) begin
                o_step_done = r_step_act && (r_step_cnt <= STEP_W'(1));
                w_state_nxt = (i_debug || o_step_done) ? StHalted : StFetch;
            end
            o_bus_fault = w_fault;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StResetChk;
            r_tmo_cnt   <= '0;
            r_step_cnt  <= '0;
            r_step_act  <= 1'b0;
            r_abs_cmd   <= 2'd0;
            r_abs_csr   <= 1'b0;
            r_burst     <= '0;
            r_abs_err   <= 1'b0;
            r_mem_store <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tmo_clr) r_tmo_cnt <= '0;
            else if (r_tmo_cnt != TmoW'(TIMEOUT)) r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
            if (r_state == StExec) r_mem_store <= (i_instr_class == ClsStore);
            if (r_state == StHalted && w_state_nxt == StFetch) begin
                r_step_act <= i_step_en;
                r_step_cnt <= !i_step_en ? '0 :
                              (i_step_count == '0) ? STEP_W'(1) : i_step_count;
            end else if (w_step_ev && r_step_act) begin
                r_step_cnt <= r_step_cnt - STEP_W'(1);
                if (r_step_cnt <= STEP_W'(1)) r_step_act <= 1'b0;
            end
            if (r_state == StHalted && i_abstract) begin
                r_abs_cmd <= i_abs_cmd;
                r_abs_csr <= i_abs_csr;
                r_burst   <= i_abs_count;
                r_abs_err <= 1'b0;
            end else if (r_state == StAbsNext) begin
                r_burst <= r_burst - BURST_W'(1);
            end else if (r_state == StAbsMem && w_fault) begin
                r_abs_err <= 1'b1;
            end
        end
    end
endmodule
